// File: rtl/mem_pkg.sv
// Shared memory-side types and constants used by the responder and the instruction/data arbiter.
package mem_pkg;

  localparam int WORD_W              = 16;
  localparam int DEFAULT_MEM_LATENCY = 4;
  localparam int MEM_ADDR_W          = 16;

  typedef struct packed {
    logic                  enable;
    logic                  wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data;
  } mem_req_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// Valid+data delay line of LATENCY stages; bubbles carry zero data so the tail is zero when invalid.
// Synchronous clear drops everything in flight; no backpressure, one shift per cycle.
module mem_resp_pipe #(
  parameter int LATENCY = 4,
  parameter int WORD_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data
);

  logic [LATENCY-1:0] vld_q;
  logic [WORD_W-1:0]  dat_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : '0;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: writes commit in the request cycle, reads return after LATENCY cycles.
// MEM_RESP_BLOCKING_EN: busy holds off all requests while a read is in flight (else busy=0, fully pipelined).
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 32768,
  parameter int LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int IDX_W  = ADDR_W - 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              accept;
  logic              rd_acc;
  logic              wr_acc;
  logic [WORD_W-1:0] rd_word;
  logic              unused_addr_lsb;

  // Byte address to word index; the low byte-select bit has no meaning for 16-bit words.
  assign idx             = addr[ADDR_W-1:1];
  assign mem_idx         = idx[MEM_AW-1:0];
  assign unused_addr_lsb = addr[0];
  assign in_range        = (int'(idx) < DEPTH);

  assign accept = enable && !busy && !rst;
  assign rd_acc = accept && !wr;
  assign wr_acc = accept && wr;

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) mem[mem_idx] <= data_in;
  end

  assign rd_word = in_range ? mem[mem_idx] : '0;

`ifdef MEM_RESP_BLOCKING_EN
  logic [3:0] hold_cnt;

  // Counts down the remaining in-flight cycles of the last accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (rd_acc) begin
      hold_cnt <= 4'(LATENCY - 1);
    end else if (hold_cnt != 4'd0) begin
      hold_cnt <= hold_cnt - 4'd1;
    end
  end

  assign busy = (hold_cnt != 4'd0);
`else
  assign busy = 1'b0;
`endif

  mem_resp_pipe #(
    .LATENCY (LATENCY),
    .WORD_W  (WORD_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (data_valid),
    .out_data  (data_out)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table plus randomized traffic against a cycle-indexed model.
module tb_mem_responder;

  localparam int L = 4;
`ifdef MEM_RESP_BLOCKING_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] data_in = 16'h0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;

  mem_responder #(.ADDR_W(16), .DEPTH(32768), .LATENCY(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tc;
    bit          r, e, w;
    logic [15:0] a, d;
    bit          ev;
    logic [15:0] ed;
    bit          eb;
  } vec_t;

  vec_t tbl[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_rd = -100;

  // Reference model: word contents plus the expected output for each absolute cycle.
  bit [15:0] mem_m [32768];
  bit        ev_m  [4096];
  bit [15:0] ed_m  [4096];

  function automatic vec_t mk(bit tc, bit r, bit e, bit w, logic [15:0] a, logic [15:0] d,
                              bit ev, logic [15:0] ed, bit eb);
    vec_t v;
    v.tc = tc; v.r = r; v.e = e; v.w = w; v.a = a; v.d = d;
    v.ev = ev; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  function automatic vec_t idl(bit ev, logic [15:0] ed, bit eb);
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, ev, ed, eb);
  endfunction

  function automatic vec_t wrv(logic [15:0] a, logic [15:0] d, bit ev, logic [15:0] ed, bit eb);
    return mk(1'b1, 1'b0, 1'b1, 1'b1, a, d, ev, ed, eb);
  endfunction

  function automatic vec_t rdv(logic [15:0] a, bit ev, logic [15:0] ed, bit eb);
    return mk(1'b1, 1'b0, 1'b1, 1'b0, a, 16'h0, ev, ed, eb);
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input vec_t v);
    bit busy_m;
    @(negedge clk);
    busy_m = BLK && (cyc > last_rd) && (cyc < last_rd + L);
    if (cyc > 0) begin
      check("model_valid", {15'h0, data_valid}, {15'h0, ev_m[cyc]});
      check("model_data", data_out, ev_m[cyc] ? ed_m[cyc] : 16'h0);
      check("model_busy", {15'h0, busy}, {15'h0, busy_m});
    end
    if (v.tc) begin
      check("tbl_valid", {15'h0, data_valid}, {15'h0, v.ev});
      check("tbl_data", data_out, v.ed);
      check("tbl_busy", {15'h0, busy}, {15'h0, v.eb});
    end
    rst = v.r; enable = v.e; wr = v.w; addr = v.a; data_in = v.d;
    if (v.r) begin
      for (int j = 1; j <= L; j++) begin
        ev_m[cyc+j] = 1'b0;
        ed_m[cyc+j] = 16'h0;
      end
      last_rd = -100;
    end else if (v.e && !busy_m) begin
      if (v.w) begin
        mem_m[v.a[15:1]] = v.d;
      end else begin
        ev_m[cyc+L] = 1'b1;
        ed_m[cyc+L] = mem_m[v.a[15:1]];
        last_rd = cyc;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    // Reset for two cycles; cycle 0 shows pre-reset outputs so it is not checked.
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0));
`ifndef MEM_RESP_BLOCKING_EN
    tbl.push_back(idl(0, 16'h0, 0));
    tbl.push_back(wrv(16'h0010, 16'hBEEF, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0010, 0, 16'h0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(idl(0, 16'h0, 0));
    tbl.push_back(idl(1, 16'hBEEF, 0));
    tbl.push_back(wrv(16'h0000, 16'h1111, 0, 16'h0, 0));
    tbl.push_back(wrv(16'h0002, 16'h2222, 0, 16'h0, 0));
    tbl.push_back(wrv(16'h0004, 16'h3333, 0, 16'h0, 0));
    tbl.push_back(wrv(16'h0006, 16'h4444, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0000, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0002, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0004, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0006, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0003, 1, 16'h1111, 0));
    tbl.push_back(idl(1, 16'h2222, 0));
    tbl.push_back(idl(1, 16'h3333, 0));
    tbl.push_back(idl(1, 16'h4444, 0));
    tbl.push_back(idl(1, 16'h2222, 0));
    tbl.push_back(wrv(16'h0020, 16'h0A0A, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0020, 0, 16'h0, 0));
    tbl.push_back(wrv(16'h0020, 16'h5555, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0020, 0, 16'h0, 0));
    tbl.push_back(idl(0, 16'h0, 0));
    tbl.push_back(idl(1, 16'h0A0A, 0));
    tbl.push_back(idl(0, 16'h0, 0));
    tbl.push_back(idl(1, 16'h5555, 0));
    tbl.push_back(rdv(16'h0000, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0002, 0, 16'h0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 0, 16'h0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(idl(0, 16'h0, 0));
    tbl.push_back(rdv(16'h0000, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0002, 0, 16'h0, 0));
    tbl.push_back(idl(0, 16'h0, 0));
    tbl.push_back(idl(0, 16'h0, 0));
    tbl.push_back(idl(1, 16'h1111, 0));
    tbl.push_back(idl(1, 16'h2222, 0));
    tbl.push_back(idl(0, 16'h0, 0));
`else
    tbl.push_back(idl(0, 16'h0, 0));
    tbl.push_back(wrv(16'h0040, 16'hABCD, 0, 16'h0, 0));
    tbl.push_back(wrv(16'h0042, 16'h1234, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0040, 0, 16'h0, 0));
    tbl.push_back(rdv(16'h0042, 0, 16'h0, 1));
    tbl.push_back(rdv(16'h0042, 0, 16'h0, 1));
    tbl.push_back(rdv(16'h0042, 0, 16'h0, 1));
    tbl.push_back(rdv(16'h0042, 1, 16'hABCD, 0));
    // A write presented while busy must be ignored.
    tbl.push_back(wrv(16'h0042, 16'hDEAD, 0, 16'h0, 1));
    tbl.push_back(idl(0, 16'h0, 1));
    tbl.push_back(idl(0, 16'h0, 1));
    tbl.push_back(rdv(16'h0042, 1, 16'h1234, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(idl(0, 16'h0, 1));
    tbl.push_back(idl(1, 16'h1234, 0));
    tbl.push_back(idl(0, 16'h0, 0));
`endif
    foreach (tbl[i]) tick(tbl[i]);

    // Preload a small working set, then randomized traffic with occasional resets.
    for (int w = 0; w < 16; w++)
      tick(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'(w * 2), 16'($urandom), 0, 16'h0, 0));
    for (int n = 0; n < 600; n++) begin
      bit          r, e, w;
      logic [15:0] a;
      r = ($urandom_range(49) == 0);
      e = ($urandom_range(3) != 0);
      w = ($urandom_range(2) == 0);
      a = 16'($urandom_range(15) * 2 + $urandom_range(1));
      tick(mk(1'b0, r, e, w, a, 16'($urandom), 0, 16'h0, 0));
    end
    for (int n = 0; n <= L; n++) tick(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 0, 16'h0, 0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multicycle main-memory responder that sits on the far side of the instruction/data memory arbiter.
- Accepts one request per cycle: enable, wr, addr, data_in.
- Writes commit in the request cycle. Reads return data_out with a one-cycle data_valid pulse exactly LATENCY cycles later.
- Backs both the IF and MEM paths in simulation and synthesis.

Parameters:
- ADDR_W, 16: byte-address width; word index = addr[ADDR_W-1:1], addr[0] ignored.
- DEPTH, 32768: number of 16-bit words in the array (must be <= 2^(ADDR_W-1)).
- LATENCY, 4: cycles from read request to data_valid; legal range 1..8.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  request present this cycle
- wr  in  1  1 = write, 0 = read; ignored when enable=0
- addr  in  ADDR_W  byte address
- data_in  in  16  write data
- data_out  out  16  read data; 16'h0000 whenever data_valid=0
- data_valid  out  1  one-cycle pulse marking returned read data
- busy  out  1  responder cannot accept a request this cycle (see Optional Feature)

Behaviour:
- Reset: when rst=1 at an edge, all LATENCY pipeline valid bits clear and data stages clear to 0.
  - Next cycle: data_valid=0, data_out=0, busy=0.
  - Array contents are NOT cleared.
  - Reads in flight when rst is asserted are dropped and never returned.
  - A request presented in the same cycle as rst=1 is ignored; a write in that cycle does not commit.
- Accept: a request is accepted when enable=1, busy=0 and rst=0.
- Write accepted in cycle k:
  - array[word] <= data_in at the end of cycle k.
  - No data_valid pulse is generated.
  - A read to the same word accepted in cycle k+1 or later returns the new value.
- Read accepted in cycle k:
  - array[word] is sampled at the end of cycle k into stage 1.
  - The value shifts one stage per cycle.
  - During cycle k+LATENCY: data_valid=1 and data_out=sampled value.
- Read data reflects array state before any write in a later cycle. A write accepted while a read to the same word is in flight does not alter the in-flight data.
- Back-to-back reads in cycles k, k+1, k+2 return in cycles k+L, k+L+1, k+L+2, in order, with no gaps.
- Only one request per cycle is possible, so there is no read/write collision inside the array.
- Out of range: word index >= DEPTH returns 16'h0000 on read; a write to it is dropped.
- enable=0 or a non-accepted request inserts a bubble (valid=0) into stage 1.

Optional Feature:
- Macro: MEM_RESP_BLOCKING_EN.
- Defined (blocking mode):
  - After a read is accepted, busy=1 for cycles k+1 .. k+LATENCY-1, and busy=0 again in cycle k+LATENCY.
  - Requests (reads and writes) presented while busy=1 are ignored; the requester must hold them.
  - busy is 0 after reset and never asserts for writes.
  - With LATENCY=1, busy is never asserted.
- Undefined (pipelined mode): busy is tied to 0 and every enabled request is accepted.

Decomposition:
- Shared package mem_pkg:
  - WORD_W=16
  - DEFAULT_MEM_LATENCY=4
  - mem_req_t struct {enable, wr, addr, data}, reused by the arbiter
- Sub-module mem_resp_pipe (parameterised by LATENCY, WORD_W): a valid+data delay line with synchronous clear.
  - Instantiated once.
  - The top level holds the array, the decode/accept logic and the busy counter.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles, release -> data_valid=0, data_out=16'h0000, busy=0 on the first post-reset cycle.
- Write then read: write 16'hBEEF to addr 16'h0010 in cycle 0, read addr 16'h0010 in cycle 1 -> data_valid=1, data_out=16'hBEEF in cycle 5 (LATENCY=4).
- Pipelined reads: preload words 0x0..0x3 = 16'h1111, 2222, 3333, 4444; read byte addresses 0,2,4,6 in consecutive cycles 0..3 -> data_valid high cycles 4..7 with the values in that order; addr 16'h0003 reads the same word as 16'h0002.
- Write during in-flight read: read addr 16'h0020 (holds 16'h0A0A) in cycle 0, write 16'h5555 to it in cycle 1 -> cycle 4 returns 16'h0A0A; a read issued in cycle 2 returns 16'h5555 in cycle 6.
- Reset mid-operation: reads issued cycles 0 and 1, rst=1 in cycle 2 -> no data_valid in cycles 4–5; array contents preserved on subsequent reads.
- MEM_RESP_BLOCKING_EN: read issued in cycle 0, read held cycles 1..4 -> busy=1 in cycles 1..3; second read accepted in cycle 4, data_valid in cycles 4 and 8 only.
